// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions.
// Fetch FSM encoding, word width and default memory size.
package cpu_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned IMEM_SIZE = 40;

  typedef logic [XLEN-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } if_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID holding register: valid bit plus instruction and PC.
// Flush beats load, load beats clear.
module if_id_reg
  import cpu_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  load_i,
  input  logic  flush_i,
  input  logic  clear_i,
  input  word_t instr_i,
  input  word_t pc_i,
  output logic  valid_o,
  output word_t instr_o,
  output word_t pc_o
);

  logic  valid_q, valid_d;
  word_t instr_q, instr_d;
  word_t pc_q, pc_d;

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      instr_d = instr_i;
      pc_d    = pc_i;
    end else if (clear_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, fetch FSM and delivered-instruction count.
// Output is staged through if_id_reg toward decode.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int unsigned MEM_SIZE = IMEM_SIZE,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        halted,
  output logic [31:0] fetch_count
);

  if_state_e state_q, state_d;
  word_t     pc_q, pc_d;
  word_t     count_q, count_d;

  logic take;
  logic in_range;
  logic load;
  logic clear;
  logic accept;

  assign take     = !if_valid || id_ready;
  assign in_range = pc_q < word_t'(MEM_SIZE);
  assign accept   = if_valid && id_ready && !redirect_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      state_d = FETCH;
    end else begin
      unique case (state_q)
        IDLE:    state_d = FETCH;
        FETCH:   if (take && !in_range) state_d = HALT;
        HALT:    state_d = HALT;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    load   = (state_q == FETCH) && !redirect_valid
           && take && in_range;
    clear  = if_valid && id_ready && !load;
    halted = (state_q == HALT);
  end

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = redirect_pc & ~word_t'(3);
    end else if (load) begin
      pc_d = pc_q + word_t'(4);
    end
  end

  assign count_d = count_q + word_t'(accept);

  if_id_reg u_if_id_reg (
    .clk     (clk),
    .reset   (reset),
    .load_i  (load),
    .flush_i (redirect_valid),
    .clear_i (clear),
    .instr_i (imem_instr),
    .pc_i    (pc_q),
    .valid_o (if_valid),
    .instr_o (if_instr),
    .pc_o    (if_pc)
  );

  assign imem_addr   = pc_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a 20-byte memory.
// Memory word at byte address a is 0x58000000 + (a>>2)*0x11.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        halted;
  logic [31:0] fetch_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mw(input logic [31:0] a);
    return 32'h5800_0000 + (a >> 2) * 32'h11;
  endfunction

  assign imem_instr = mw(imem_addr);

  instr_fetch #(.MEM_SIZE(20), .RESET_PC(32'd0)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .halted         (halted),
    .fetch_count    (fetch_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40; id_ready = 1'b1;
    tick(); tick();
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", if_valid); end
    checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h want 0", if_pc); end
    checks++; if (if_instr !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h want 0", if_instr); end
    checks++; if (fetch_count !== 32'h0) begin errors++; $display("FAIL rst_count: got %0d want 0", fetch_count); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h want 0", imem_addr); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted: got %b want 0", halted); end
  endtask

  task automatic test_stream();
    reset = 1'b0; redirect_valid = 1'b0;
    tick();
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL idle_valid: got %b want 0", if_valid); end
    tick();
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== 32'h5800_0000) begin errors++; $display("FAIL first: got v=%b pc=%h i=%h want 1 0 58000000", if_valid, if_pc, if_instr); end
    for (int k = 1; k <= 2; k++) begin
      tick();
      checks++; if (if_pc !== 32'(4 * k) || if_instr !== mw(32'(4 * k)) || fetch_count !== 32'(k)) begin errors++; $display("FAIL stream%0d: got pc=%h i=%h n=%0d want %h %h %0d", k, if_pc, if_instr, fetch_count, 4 * k, mw(32'(4 * k)), k); end
    end
  endtask

  task automatic test_stall();
    id_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (if_valid !== 1'b1 || if_pc !== 32'h8 || if_instr !== mw(32'h8) || fetch_count !== 32'd2) begin errors++; $display("FAIL stall%0d: got v=%b pc=%h i=%h n=%0d want 1 8 %h 2", k, if_valid, if_pc, if_instr, fetch_count, mw(32'h8)); end
    end
    id_ready = 1'b1;
    tick();
    checks++; if (if_pc !== 32'hC || fetch_count !== 32'd3) begin errors++; $display("FAIL unstall: got pc=%h n=%0d want c 3", if_pc, fetch_count); end
  endtask

  task automatic test_halt();
    tick();
    checks++; if (if_pc !== 32'h10 || fetch_count !== 32'd4 || halted !== 1'b0) begin errors++; $display("FAIL last: got pc=%h n=%0d h=%b want 10 4 0", if_pc, fetch_count, halted); end
    id_ready = 1'b0;
    tick();
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h10 || halted !== 1'b0) begin errors++; $display("FAIL pend: got v=%b pc=%h h=%b want 1 10 0", if_valid, if_pc, halted); end
    id_ready = 1'b1;
    tick();
    checks++; if (halted !== 1'b1 || if_valid !== 1'b0 || fetch_count !== 32'd5) begin errors++; $display("FAIL halt: got h=%b v=%b n=%0d want 1 0 5", halted, if_valid, fetch_count); end
    tick();
    checks++; if (halted !== 1'b1 || if_valid !== 1'b0 || imem_addr !== 32'd20 || fetch_count !== 32'd5) begin errors++; $display("FAIL halt_hold: got h=%b v=%b a=%0d n=%0d want 1 0 20 5", halted, if_valid, imem_addr, fetch_count); end
  endtask

  task automatic test_redirect_halt();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_000A;
    tick();
    checks++; if (halted !== 1'b0 || if_valid !== 1'b0 || imem_addr !== 32'h8) begin errors++; $display("FAIL rd_halt: got h=%b v=%b a=%h want 0 0 8", halted, if_valid, imem_addr); end
    redirect_valid = 1'b0;
    tick();
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h8 || if_instr !== mw(32'h8) || fetch_count !== 32'd5) begin errors++; $display("FAIL rd_load: got v=%b pc=%h i=%h n=%0d want 1 8 %h 5", if_valid, if_pc, if_instr, fetch_count, mw(32'h8)); end
  endtask

  task automatic test_redirect_stall();
    redirect_valid = 1'b1; redirect_pc = 32'h4;
    tick();
    checks++; if (if_valid !== 1'b0 || fetch_count !== 32'd5) begin errors++; $display("FAIL rd_drop: got v=%b n=%0d want 0 5", if_valid, fetch_count); end
    redirect_valid = 1'b0; id_ready = 1'b0;
    tick(); tick();
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h4) begin errors++; $display("FAIL rs_stall: got v=%b pc=%h want 1 4", if_valid, if_pc); end
    redirect_valid = 1'b1; redirect_pc = 32'h10;
    tick();
    checks++; if (if_valid !== 1'b0 || fetch_count !== 32'd5) begin errors++; $display("FAIL rs_flush: got v=%b n=%0d want 0 5", if_valid, fetch_count); end
    redirect_valid = 1'b0;
    tick();
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h10 || fetch_count !== 32'd5) begin errors++; $display("FAIL rs_target: got v=%b pc=%h n=%0d want 1 10 5", if_valid, if_pc, fetch_count); end
  endtask

  task automatic test_reset_stall();
    redirect_valid = 1'b1; redirect_pc = 32'hC;
    tick();
    redirect_valid = 1'b0;
    tick(); tick();
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'hC) begin errors++; $display("FAIL rr_setup: got v=%b pc=%h want 1 c", if_valid, if_pc); end
    reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h8;
    tick();
    checks++; if (if_valid !== 1'b0 || imem_addr !== 32'h0 || fetch_count !== 32'd0 || halted !== 1'b0) begin errors++; $display("FAIL rr_reset: got v=%b a=%h n=%0d h=%b want 0 0 0 0", if_valid, imem_addr, fetch_count, halted); end
    reset = 1'b0; redirect_valid = 1'b0; id_ready = 1'b1;
    tick();
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rr_idle: got v=%b want 0", if_valid); end
    tick();
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== 32'h5800_0000) begin errors++; $display("FAIL rr_first: got v=%b pc=%h i=%h want 1 0 58000000", if_valid, if_pc, if_instr); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_halt();
    test_redirect_halt();
    test_redirect_stall();
    test_reset_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter MEM_SIZE, default 40: instruction memory size in bytes; fetch addresses >= MEM_SIZE are out of range.
REQ-002 SHALL have parameter RESET_PC, default 0: PC value loaded on reset.
REQ-003 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port imem_addr, output, 32: byte address to the instruction memory; combinational copy of the PC.
REQ-006 SHALL have port imem_instr, input, 32: instruction word returned combinationally by the memory for imem_addr.
REQ-007 SHALL have port redirect_valid, input, 1: branch/jump redirect request.
REQ-008 SHALL have port redirect_pc, input, 32: redirect target byte address.
REQ-009 SHALL have port id_ready, input, 1: decode stage accepts the output this cycle.
REQ-010 SHALL have port if_valid, output, 1: if_instr/if_pc hold a valid fetched instruction.
REQ-011 SHALL have port if_instr, output, 32: registered fetched instruction.
REQ-012 SHALL have port if_pc, output, 32: byte address of if_instr.
REQ-013 SHALL have port halted, output, 1: high while in HALT.
REQ-014 SHALL have port fetch_count, output, 32: number of instructions handed to decode.

Function
REQ-015 SHALL implement FSM states IDLE, FETCH, HALT.
REQ-016 IDLE: no fetch, if_valid=0; SHALL go to FETCH on the next cycle unconditionally unless redirect_valid (see REQ-021).
REQ-017 FETCH: a "load" occurs when (if_valid==0 or id_ready==1) and pc < MEM_SIZE; on load: if_instr<=imem_instr, if_pc<=pc, if_valid<=1, pc<=pc+4 (32-bit wrap, no carry-out).
REQ-018 FETCH, if_valid==1 and id_ready==0: if_instr, if_pc, if_valid, pc SHALL hold (stall).
REQ-019 FETCH, load condition met but pc >= MEM_SIZE: SHALL go to HALT; if_valid<=0 if id_ready==1 else hold the pending instruction until accepted, then clear.
REQ-020 HALT: no fetch, pc holds; pending output drains per REQ-019; leaves HALT only via redirect or reset.
REQ-021 redirect_valid SHALL take priority over every other event in any state: pc<={redirect_pc[31:2],2'b00}, if_valid<=0 (pending instruction discarded, not counted), state<=FETCH.
REQ-022 fetch_count SHALL increment by 1 on every cycle with if_valid==1 and id_ready==1 and redirect_valid==0; wraps at 2^32.
REQ-023 Latency: an instruction at pc is visible on if_instr the cycle after its load; sustained throughput one instruction per cycle when id_ready held high.
REQ-024 halted SHALL be registered state decode (high exactly while state==HALT).

Reset
REQ-025 On reset: state<=IDLE, pc<=RESET_PC, if_valid<=0, if_instr<=0, if_pc<=0, fetch_count<=0; reset overrides redirect_valid.
REQ-026 Reset asserted mid-stall or mid-HALT SHALL discard the pending instruction with no count increment.

Structure
REQ-027 FSM state encoding, MEM_SIZE default and the instruction width (32) SHALL live in a shared package cpu_pkg.
REQ-028 The output register stage SHALL be a sub-module if_id_reg (valid/data holding register with load and flush); PC/FSM logic stays in instr_fetch.

Verification
REQ-029 Reset then release, id_ready=1, memory word at 0 = 0x58000000 -> cycle 1 IDLE, cycle 2 if_valid=1, if_pc=0, if_instr=0x58000000; then if_pc 4,8,12 on consecutive cycles.
REQ-030 if_valid=1 at if_pc=8, id_ready=0 for 3 cycles -> if_pc=8, if_instr constant, fetch_count constant; id_ready=1 -> if_pc=12 next cycle.
REQ-031 MEM_SIZE=20, id_ready=1 -> five instructions (pc 0..16), fetch_count=5, halted=1, if_valid=0 thereafter; pc stays 20.
REQ-032 In HALT, redirect_valid=1 with redirect_pc=0x0000000A -> halted=0, next load at pc=8, if_pc=8.
REQ-033 Stalled with if_pc=4, redirect_valid=1, redirect_pc=16 -> if_valid=0 next cycle, fetch_count unchanged, following if_pc=16.
REQ-034 reset asserted while stalled at if_pc=12 with redirect_valid=1 -> IDLE, pc=RESET_PC, if_valid=0, fetch_count=0.
